// File: rtl/axi_write_master_if.sv
// AXI4 write-address, write-data and write-response channel bundle
// seen from the master side (master) or the attached slave (slave).
interface axi_write_master_if #(
  parameter int AW  = 32,
  parameter int DW  = 64,
  parameter int IDW = 4
);
  logic [IDW-1:0]  m_axi_awid;
  logic [AW-1:0]   m_axi_awaddr;
  logic [7:0]      m_axi_awlen;
  logic [2:0]      m_axi_awsize;
  logic [1:0]      m_axi_awburst;
  logic            m_axi_awvalid;
  logic            m_axi_awready;
  logic [DW-1:0]   m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic            m_axi_wlast;
  logic            m_axi_wvalid;
  logic            m_axi_wready;
  logic [IDW-1:0]  m_axi_bid;
  logic [1:0]      m_axi_bresp;
  logic            m_axi_bvalid;
  logic            m_axi_bready;

  modport master (
    output m_axi_awid,
    output m_axi_awaddr,
    output m_axi_awlen,
    output m_axi_awsize,
    output m_axi_awburst,
    output m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata,
    output m_axi_wstrb,
    output m_axi_wlast,
    output m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bid,
    input  m_axi_bresp,
    input  m_axi_bvalid,
    output m_axi_bready
  );

  modport slave (
    input  m_axi_awid,
    input  m_axi_awaddr,
    input  m_axi_awlen,
    input  m_axi_awsize,
    input  m_axi_awburst,
    input  m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata,
    input  m_axi_wstrb,
    input  m_axi_wlast,
    input  m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bid,
    output m_axi_bresp,
    output m_axi_bvalid,
    input  m_axi_bready
  );
endinterface

// File: rtl/axi_write_master.sv
// AXI4 write master: multiple bursts in flight, per-burst WLAST
// sequencing, burst legalisation and a buffered B response port.
module axi_write_master #(
  parameter int AW          = 32,
  parameter int DW          = 64,
  parameter int IDW         = 4,
  parameter int OUTSTANDING = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [AW-1:0]                    cmd_addr,
  input  logic [7:0]                       cmd_len,
  input  logic [2:0]                       cmd_size,
  input  logic [1:0]                       cmd_burst,
  input  logic [IDW-1:0]                   cmd_id,
  input  logic [DW-1:0]                    wdata_in,
  input  logic [DW/8-1:0]                  wstrb_in,
  input  logic                             wvalid_in,
  output logic                             wready_out,
  axi_write_master_if.master               m_axi,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [IDW-1:0]                   resp_id,
  output logic [1:0]                       resp_resp,
  output logic [$clog2(OUTSTANDING+1)-1:0] outstanding,
  output logic [2:0]                       err_status
);

  localparam int SW   = DW / 8;
  localparam int MAXS = $clog2(SW);
  localparam int CW   = $clog2(OUTSTANDING + 1);
  localparam int PW   = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [1:0] BURST_RSVD = 2'b11;

  typedef enum logic {
    W_IDLE,
    W_BURST
  } w_state_e;

  logic           r_awvalid;
  logic [IDW-1:0] r_awid;
  logic [AW-1:0]  r_awaddr;
  logic [7:0]     r_awlen;
  logic [2:0]     r_awsize;
  logic [1:0]     r_awburst;

  logic [7:0]     r_q [OUTSTANDING];
  logic [PW-1:0]  r_wp;
  logic [PW-1:0]  r_rp;
  logic [CW-1:0]  r_qcnt;

  w_state_e       r_wstate;
  logic [7:0]     r_beat_cnt;

  logic [CW-1:0]  r_out;
  logic [2:0]     r_err;
  logic           r_resp_valid;
  logic [IDW-1:0] r_resp_id;
  logic [1:0]     r_resp_resp;

  logic           w_accept;
  logic           w_aw_hs;
  logic           w_in_burst;
  logic           w_wlast;
  logic           w_w_hs;
  logic           w_q_empty;
  logic           w_q_full;
  logic           w_push;
  logic           w_pop;
  logic           w_bready;
  logic           w_b_hs;
  logic           w_b_dec;
  logic           w_wrap_ok;
  logic [1:0]     w_leg_burst;
  logic [2:0]     w_leg_size;
  logic           w_leg_flag;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    if (p == PW'(OUTSTANDING - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign cmd_ready = !r_awvalid
                  && (r_out < CW'(OUTSTANDING))
                  && !rst;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_aw_hs   = r_awvalid && m_axi.m_axi_awready;

  assign w_wrap_ok = (cmd_len == 8'd1) || (cmd_len == 8'd3)
                  || (cmd_len == 8'd7) || (cmd_len == 8'd15);

  always_comb begin
    w_leg_burst = cmd_burst;
    w_leg_size  = cmd_size;
    w_leg_flag  = 1'b0;
    unique case (1'b1)
      (cmd_burst == BURST_RSVD),
      (cmd_burst == BURST_WRAP && !w_wrap_ok): begin
        w_leg_burst = BURST_INCR;
        w_leg_flag  = 1'b1;
      end
      default: ;
    endcase
    if (cmd_size > 3'(MAXS)) begin
      w_leg_size = 3'(MAXS);
      w_leg_flag = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_awvalid <= 1'b0;
      r_awid    <= '0;
      r_awaddr  <= '0;
      r_awlen   <= '0;
      r_awsize  <= '0;
      r_awburst <= '0;
    end else if (w_accept) begin
      r_awvalid <= 1'b1;
      r_awid    <= cmd_id;
      r_awaddr  <= cmd_addr;
      r_awlen   <= cmd_len;
      r_awsize  <= w_leg_size;
      r_awburst <= w_leg_burst;
    end else if (w_aw_hs) begin
      r_awvalid <= 1'b0;
    end
  end

  // Burst-length queue: holds bursts whose W beats have not started.
  assign w_q_empty  = (r_qcnt == '0);
  assign w_q_full   = (r_qcnt == CW'(OUTSTANDING));
  assign w_in_burst = (r_wstate == W_BURST);
  assign w_wlast    = (r_beat_cnt == 8'd0);
  assign w_w_hs     = w_in_burst && wvalid_in && m_axi.m_axi_wready;
  assign w_pop      = !w_q_empty
                   && (!w_in_burst || (w_w_hs && w_wlast));
  assign w_push     = w_accept && (!w_q_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_q[r_wp] <= cmd_len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_qcnt <= '0;
    end else begin
      if (w_push) r_wp <= f_next(r_wp);
      if (w_pop)  r_rp <= f_next(r_rp);
      unique case ({w_push, w_pop})
        2'b10:   r_qcnt <= r_qcnt + CW'(1);
        2'b01:   r_qcnt <= r_qcnt - CW'(1);
        default: ;
      endcase
    end
  end

  // Back-to-back bursts reload the counter on the WLAST beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate   <= W_IDLE;
      r_beat_cnt <= '0;
    end else begin
      unique case (r_wstate)
        W_IDLE: begin
          if (!w_q_empty) begin
            r_beat_cnt <= r_q[r_rp];
            r_wstate   <= W_BURST;
          end
        end
        W_BURST: begin
          if (w_w_hs) begin
            if (!w_wlast)        r_beat_cnt <= r_beat_cnt - 8'd1;
            else if (!w_q_empty) r_beat_cnt <= r_q[r_rp];
            else                 r_wstate   <= W_IDLE;
          end
        end
      endcase
    end
  end

  assign w_bready = !rst && (!r_resp_valid || resp_ready);
  assign w_b_hs   = m_axi.m_axi_bvalid && w_bready;
  assign w_b_dec  = w_b_hs && (r_out != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out        <= '0;
      r_err        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_resp  <= '0;
    end else begin
      unique case ({w_accept, w_b_dec})
        2'b10:   r_out <= r_out + CW'(1);
        2'b01:   r_out <= r_out - CW'(1);
        default: ;
      endcase
      if (w_accept && w_leg_flag)           r_err[1] <= 1'b1;
      if (w_b_hs && (r_out == '0))          r_err[2] <= 1'b1;
      if (w_b_hs && m_axi.m_axi_bresp[1])   r_err[0] <= 1'b1;
      if (w_b_hs) begin
        r_resp_valid <= 1'b1;
        r_resp_id    <= m_axi.m_axi_bid;
        r_resp_resp  <= m_axi.m_axi_bresp;
      end else if (resp_ready) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  assign m_axi.m_axi_awid    = r_awid;
  assign m_axi.m_axi_awaddr  = r_awaddr;
  assign m_axi.m_axi_awlen   = r_awlen;
  assign m_axi.m_axi_awsize  = r_awsize;
  assign m_axi.m_axi_awburst = r_awburst;
  assign m_axi.m_axi_awvalid = r_awvalid;
  assign m_axi.m_axi_wdata   = wdata_in;
  assign m_axi.m_axi_wstrb   = wstrb_in;
  assign m_axi.m_axi_wvalid  = w_in_burst && wvalid_in;
  assign m_axi.m_axi_wlast   = w_in_burst && w_wlast;
  assign m_axi.m_axi_bready  = w_bready;
  assign wready_out          = w_in_burst && m_axi.m_axi_wready;

  assign resp_valid  = r_resp_valid;
  assign resp_id     = r_resp_id;
  assign resp_resp   = r_resp_resp;
  assign outstanding = r_out;
  assign err_status  = r_err;

endmodule

// File: tb/tb_axi_write_master.sv
// Bench for axi_write_master: transaction-level model plus directed
// scenarios covering issue, W sequencing, backpressure and reset.
module tb_axi_write_master;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int IDW = 4;
  localparam int OUT = 4;
  localparam int CW  = $clog2(OUT + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [AW-1:0]   cmd_addr;
  logic [7:0]      cmd_len;
  logic [2:0]      cmd_size;
  logic [1:0]      cmd_burst;
  logic [IDW-1:0]  cmd_id;
  logic [DW-1:0]   wdata_in;
  logic [DW/8-1:0] wstrb_in;
  logic            wvalid_in;
  logic            wready_out;
  logic            resp_valid;
  logic            resp_ready;
  logic [IDW-1:0]  resp_id;
  logic [1:0]      resp_resp;
  logic [CW-1:0]   outstanding;
  logic [2:0]      err_status;

  axi_write_master_if #(.AW(AW), .DW(DW), .IDW(IDW)) bus();

  axi_write_master #(
    .AW(AW), .DW(DW), .IDW(IDW), .OUTSTANDING(OUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_size   (cmd_size),
    .cmd_burst  (cmd_burst),
    .cmd_id     (cmd_id),
    .wdata_in   (wdata_in),
    .wstrb_in   (wstrb_in),
    .wvalid_in  (wvalid_in),
    .wready_out (wready_out),
    .m_axi      (bus),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_resp  (resp_resp),
    .outstanding(outstanding),
    .err_status (err_status)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit started = 1'b0;

  // Transaction-level model state
  int             m_cnt = 0;
  bit             m_awp = 1'b0;
  logic [IDW-1:0] m_aw_id;
  logic [AW-1:0]  m_aw_addr;
  logic [7:0]     m_aw_len;
  logic [2:0]     m_aw_size;
  logic [1:0]     m_aw_burst;
  logic [2:0]     m_err = '0;
  bit             m_rv = 1'b0;
  logic [IDW-1:0] m_rid = '0;
  logic [1:0]     m_rresp = '0;
  bit             wexp[$];

  logic           wlog[$];
  int             wcyc[$];
  logic [IDW-1:0] dlv[$];

  bit         a_acc, a_bhs, a_lf;
  logic [1:0] a_lb;
  logic [2:0] a_ls;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", n, a, e, $time);
    end
  endtask

  // Legal AXI form of a command: 8-byte bus, so size tops out at 3.
  function automatic void legal(input logic [1:0] b, input logic [7:0] l,
                                input logic [2:0] s, output logic [1:0] ob,
                                output logic [2:0] os, output bit f);
    ob = b; os = s; f = 1'b0;
    if (b == 2'b11 || (b == 2'b10 && !(l inside {8'd1, 8'd3, 8'd7, 8'd15}))) begin
      ob = 2'b01; f = 1'b1;
    end
    if (s > 3'd3) begin
      os = 3'd3; f = 1'b1;
    end
  endfunction

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      m_cnt = 0; m_awp = 1'b0; m_err = '0; m_rv = 1'b0;
      wexp.delete();
    end else begin
      a_acc = cmd_valid && !m_awp && (m_cnt < OUT);
      a_bhs = bus.m_axi_bvalid && (!m_rv || resp_ready);
      if (bus.m_axi_wvalid && bus.m_axi_wready && wexp.size() > 0)
        void'(wexp.pop_front());
      if (m_awp && bus.m_axi_awready) m_awp = 1'b0;
      if (a_bhs) begin
        if (m_cnt == 0) m_err[2] = 1'b1;
        else m_cnt--;
        if (bus.m_axi_bresp[1]) m_err[0] = 1'b1;
        m_rv = 1'b1; m_rid = bus.m_axi_bid; m_rresp = bus.m_axi_bresp;
      end else if (resp_ready) begin
        m_rv = 1'b0;
      end
      if (a_acc) begin
        legal(cmd_burst, cmd_len, cmd_size, a_lb, a_ls, a_lf);
        if (a_lf) m_err[1] = 1'b1;
        m_awp = 1'b1; m_cnt++;
        m_aw_id = cmd_id; m_aw_addr = cmd_addr; m_aw_len = cmd_len;
        m_aw_size = a_ls; m_aw_burst = a_lb;
        for (int i = 0; i <= int'(cmd_len); i++) wexp.push_back(i == int'(cmd_len));
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      cyc++;
      chk("cmd_ready", cmd_ready, !rst && !m_awp && (m_cnt < OUT));
      chk("awvalid", bus.m_axi_awvalid, m_awp);
      if (m_awp) begin
        chk("awid", bus.m_axi_awid, m_aw_id);
        chk("awaddr", bus.m_axi_awaddr, m_aw_addr);
        chk("awlen", bus.m_axi_awlen, m_aw_len);
        chk("awsize", bus.m_axi_awsize, m_aw_size);
        chk("awburst", bus.m_axi_awburst, m_aw_burst);
      end
      chk("outstanding", outstanding, m_cnt);
      chk("err_status", err_status, m_err);
      chk("resp_valid", resp_valid, m_rv);
      if (m_rv) begin
        chk("resp_id", resp_id, m_rid);
        chk("resp_resp", resp_resp, m_rresp);
      end
      chk("bready", bus.m_axi_bready, !rst && (!m_rv || resp_ready));
      chk("w_handshake", wvalid_in && wready_out,
          bus.m_axi_wvalid && bus.m_axi_wready);
      if (wexp.size() == 0) chk("wvalid_idle", bus.m_axi_wvalid, 1'b0);
      if (bus.m_axi_wvalid) begin
        chk("wdata", bus.m_axi_wdata, wdata_in);
        chk("wstrb", bus.m_axi_wstrb, wstrb_in);
      end
      if (bus.m_axi_wvalid && bus.m_axi_wready) begin
        if (wexp.size() > 0) chk("wlast", bus.m_axi_wlast, wexp[0]);
        wlog.push_back(bus.m_axi_wlast);
        wcyc.push_back(cyc);
      end
      if (resp_valid && resp_ready) dlv.push_back(resp_id);
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      wdata_in = {$urandom, $urandom};
      wstrb_in = 8'($urandom);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic [AW-1:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [1:0] b,
                          input logic [IDW-1:0] id);
    bit ok = 1'b0;
    cmd_addr = a; cmd_len = l; cmd_size = s; cmd_burst = b; cmd_id = id;
    cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    chk("cmd_accept_timeout", ok, 1'b1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_b(input logic [IDW-1:0] id, input logic [1:0] r);
    bit ok = 1'b0;
    bus.m_axi_bid = id; bus.m_axi_bresp = r; bus.m_axi_bvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.m_axi_bready) begin ok = 1'b1; break; end
    end
    chk("b_accept_timeout", ok, 1'b1);
    tick();
    bus.m_axi_bvalid = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (wlog.size() >= n) begin ok = 1'b1; break; end
    end
    chk("w_beats_timeout", ok, 1'b1);
    tick();
  endtask

  function automatic int wpatt(input int n);
    int p = 0;
    for (int i = 0; i < n && i < wlog.size(); i++)
      if (wlog[i]) p |= (1 << i);
    return p;
  endfunction

  initial begin
    cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
    cmd_burst = '0; cmd_id = '0; wvalid_in = 1'b0; resp_ready = 1'b0;
    wdata_in = '0; wstrb_in = '0;
    bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0;
    bus.m_axi_bvalid = 1'b0; bus.m_axi_bid = '0; bus.m_axi_bresp = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awvalid", bus.m_axi_awvalid, 1'b0);
    chk("rst_bready", bus.m_axi_bready, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err_status, 3'b000);
    chk("rst_resp_valid", resp_valid, 1'b0);
    rst = 1'b0;
    tick();

    // Single INCR burst, slave always ready
    bus.m_axi_awready = 1'b1; bus.m_axi_wready = 1'b1;
    wvalid_in = 1'b1; resp_ready = 1'b1;
    wlog.delete();
    send_cmd(32'h0000_1000, 8'd3, 3'd3, 2'b01, 4'd2);
    chk("t1_awvalid", bus.m_axi_awvalid, 1'b1);
    chk("t1_awlen", bus.m_axi_awlen, 3);
    chk("t1_outst1", outstanding, 1);
    tick();
    chk("t1_awvalid_drop", bus.m_axi_awvalid, 1'b0);
    wait_beats(4);
    chk("t1_wlast_pattern", wpatt(4), 4'b1000);
    send_b(4'd2, 2'b00);
    chk("t1_resp_valid", resp_valid, 1'b1);
    chk("t1_resp_id", resp_id, 4'd2);
    chk("t1_resp", resp_resp, 2'b00);
    chk("t1_outst0", outstanding, 0);
    tick();

    // Five commands against a four-deep outstanding limit
    for (int i = 0; i < 4; i++)
      send_cmd(32'h2000 + 32'(i * 8), 8'd0, 3'd3, 2'b01, IDW'(i));
    cmd_addr = 32'h3000; cmd_len = 8'd0; cmd_size = 3'd3;
    cmd_burst = 2'b01; cmd_id = 4'd4; cmd_valid = 1'b1;
    repeat (3) tick();
    chk("t2_ready_full", cmd_ready, 1'b0);
    chk("t2_outst_full", outstanding, 4);
    send_b(4'd0, 2'b00);
    chk("t2_ready_after_b", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    chk("t2_outst_refill", outstanding, 4);
    for (int i = 1; i < 5; i++) send_b(IDW'(i), 2'b00);
    repeat (2) tick();
    chk("t2_outst_drained", outstanding, 0);

    // Back-to-back bursts with no bubble
    bus.m_axi_wready = 1'b0;
    send_cmd(32'h4000, 8'd0, 3'd3, 2'b01, 4'd7);
    send_cmd(32'h4100, 8'd1, 3'd3, 2'b01, 4'd8);
    tick();
    wlog.delete(); wcyc.delete();
    bus.m_axi_wready = 1'b1;
    wait_beats(3);
    chk("t3_wlast_pattern", wpatt(3), 3'b101);
    if (wcyc.size() >= 3) begin
      chk("t3_gap1", wcyc[1] - wcyc[0], 1);
      chk("t3_gap2", wcyc[2] - wcyc[1], 1);
    end
    send_b(4'd7, 2'b00);
    send_b(4'd8, 2'b00);

    // Legalisation of burst type and size
    wlog.delete();
    send_cmd(32'h5000, 8'd5, 3'd2, 2'b10, 4'd1);
    chk("t4_awburst", bus.m_axi_awburst, 2'b01);
    chk("t4_err", err_status, 3'b010);
    send_cmd(32'h5100, 8'd0, 3'd7, 2'b01, 4'd3);
    chk("t4_awsize", bus.m_axi_awsize, 3'd3);
    wait_beats(7);
    send_b(4'd1, 2'b00);
    send_b(4'd3, 2'b00);
    tick();

    // Response backpressure with an error response
    resp_ready = 1'b0;
    wlog.delete(); dlv.delete();
    send_cmd(32'h6000, 8'd0, 3'd3, 2'b01, 4'd5);
    send_cmd(32'h6100, 8'd0, 3'd3, 2'b01, 4'd6);
    wait_beats(2);
    send_b(4'd5, 2'b10);
    chk("t5_err0", err_status[0], 1'b1);
    fork
      send_b(4'd6, 2'b00);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("t5_bready_low", bus.m_axi_bready, 1'b0);
        end
        tick();
        resp_ready = 1'b1;
      end
    join
    repeat (3) tick();
    chk("t5_dlv_count", dlv.size(), 2);
    if (dlv.size() >= 2) begin
      chk("t5_dlv0", dlv[0], 4'd5);
      chk("t5_dlv1", dlv[1], 4'd6);
    end
    chk("t5_err", err_status, 3'b011);

    // Reset in the middle of a burst, then a stray B
    wlog.delete();
    send_cmd(32'h7000, 8'd3, 3'd3, 2'b01, 4'd9);
    wait_beats(1);
    rst = 1'b1;
    tick();
    chk("t6_wvalid", bus.m_axi_wvalid, 1'b0);
    chk("t6_awvalid", bus.m_axi_awvalid, 1'b0);
    chk("t6_outst", outstanding, 0);
    chk("t6_err", err_status, 3'b000);
    chk("t6_resp_valid", resp_valid, 1'b0);
    rst = 1'b0;
    repeat (2) tick();
    send_b(4'hA, 2'b00);
    chk("t6_stray_err", err_status, 3'b100);
    chk("t6_stray_resp", resp_valid, 1'b1);
    chk("t6_stray_outst", outstanding, 0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail + 1);
    $fatal(1);
  end

endmodule
